// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths and types for the register-file writeback arbiter slice.
// Writeback entries are carried as one packed struct between slots and the select logic.
package regfile_write_arbiter_pkg;

  localparam int DATA_BUS_WIDTH    = 24;
  localparam int REGFILE_ADDR_BITS = 4;
  localparam int NUM_REGISTERS     = 16;

  typedef logic [REGFILE_ADDR_BITS-1:0] reg_addr_t;
  typedef logic [DATA_BUS_WIDTH-1:0]    reg_data_t;

  typedef struct packed {
    logic      vld;
    reg_addr_t addr;
    reg_data_t dat;
  } wb_entry_t;

  // r0 is hardwired to zero in regFile, so a write there is dropped.
  function automatic logic is_writable(input reg_addr_t addr);
    return (addr != '0) && (int'(addr) < NUM_REGISTERS);
  endfunction

  function automatic logic pending_on(input wb_entry_t entry, input reg_addr_t rd_addr);
    return entry.vld && (entry.addr == rd_addr) && (rd_addr != '0);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_wb_slot.sv
// wb_slot: one-entry writeback holder; load wins over clear so a draining slot can refill.
// Latency 1 cycle (load visible after the posedge); no backpressure of its own.
module regfile_write_arbiter_wb_slot
  import regfile_write_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      load,
  input  logic      clear,
  input  reg_addr_t load_addr,
  input  reg_data_t load_data,
  output wb_entry_t entry
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry <= '0;
    end else if (load) begin
      entry <= '{vld: 1'b1, addr: load_addr, dat: load_data};
    end else if (clear) begin
      entry.vld <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writebacks onto the single regFile write port, oldest first.
// Latency 1 cycle accept-to-write; reqN_ready drops only while slot N is held and not draining.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic [REGFILE_ADDR_BITS-1:0] req0_addr,
  input  logic [DATA_BUS_WIDTH-1:0]    req0_data,
  input  logic                         req1_valid,
  output logic                         req1_ready,
  input  logic [REGFILE_ADDR_BITS-1:0] req1_addr,
  input  logic [DATA_BUS_WIDTH-1:0]    req1_data,
  output logic [REGFILE_ADDR_BITS-1:0] write_address,
  output logic [DATA_BUS_WIDTH-1:0]    write_data,
  output logic                         write_enable,
  input  logic [REGFILE_ADDR_BITS-1:0] read_address1,
  input  logic [REGFILE_ADDR_BITS-1:0] read_address2,
  output logic                         hazard1,
  output logic                         hazard2,
  output logic                         busy
);

  wb_entry_t slot0;
  wb_entry_t slot1;
  wb_entry_t sel_entry;
  logic      older1;
  logic      older1_nxt;
  logic      sel1;
  logic      grant0;
  logic      grant1;
  logic      load0;
  logic      load1;
  logic      hold0;
  logic      hold1;

  // older1 only matters when both slots are valid.
  assign sel1   = slot1.vld && (!slot0.vld || older1);
  assign grant1 = sel1;
  assign grant0 = slot0.vld && !sel1;

  assign req0_ready = !slot0.vld || grant0;
  assign req1_ready = !slot1.vld || grant1;
  assign load0      = req0_valid && req0_ready;
  assign load1      = req1_valid && req1_ready;

  assign hold0 = slot0.vld && !grant0;
  assign hold1 = slot1.vld && !grant1;

  regfile_write_arbiter_wb_slot u_slot0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load0),
    .clear     (grant0),
    .load_addr (req0_addr),
    .load_data (req0_data),
    .entry     (slot0)
  );

  regfile_write_arbiter_wb_slot u_slot1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load1),
    .clear     (grant1),
    .load_addr (req1_addr),
    .load_data (req1_data),
    .entry     (slot1)
  );

  // Simultaneous arrivals put the ALU result first, matching program order.
  always_comb begin
    older1_nxt = older1;
    if (load0 && load1) begin
      older1_nxt = 1'b0;
    end else if (load0) begin
      older1_nxt = hold1;
    end else if (load1) begin
      older1_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      older1 <= 1'b0;
    end else begin
      older1 <= older1_nxt;
    end
  end

  // Stale addr/data of a cleared slot are masked so the port reads zero when idle.
  always_comb begin
    sel_entry = '0;
    if (sel1) begin
      sel_entry = slot1;
    end else if (slot0.vld) begin
      sel_entry = slot0;
    end
  end

  assign write_address = sel_entry.addr;
  assign write_data    = sel_entry.dat;
  assign write_enable  = sel_entry.vld && is_writable(sel_entry.addr);

  // The draining slot still counts: regFile only commits at the following negedge.
  assign hazard1 = pending_on(slot0, read_address1) || pending_on(slot1, read_address1);
  assign hazard2 = pending_on(slot0, read_address2) || pending_on(slot1, read_address2);
  assign busy    = slot0.vld || slot1.vld;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: accepted requests queue their expected write, a negedge monitor pops and compares.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_addr, req1_addr, write_address, read_address1, read_address2;
  logic [23:0] req0_data, req1_data, write_data;
  logic        write_enable, hazard1, hazard2, busy;

  typedef struct packed {
    logic [3:0]  a;
    logic [23:0] d;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [23:0] rf[16];
  int          checks = 0;
  int          errors = 0;
  logic        acc0, acc1;
  int          i0, i1;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_addr     (req0_addr),
    .req0_data     (req0_data),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_addr     (req1_addr),
    .req1_data     (req1_data),
    .write_address (write_address),
    .write_data    (write_data),
    .write_enable  (write_enable),
    .read_address1 (read_address1),
    .read_address2 (read_address2),
    .hazard1       (hazard1),
    .hazard2       (hazard2),
    .busy          (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of regFile plus scoreboard check: every write must match the oldest accepted request.
  initial begin
    forever begin
      @(negedge clk);
      if (write_enable) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got r%0d=%06h expected no write", write_address, write_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_addr", 32'(write_address), 32'(mon_e.a));
          chk("write_data", 32'(write_data), 32'(mon_e.d));
        end
        rf[write_address] = write_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request cycle: handshake is decided by ready just before the posedge.
  task automatic cycle(output logic a0, output logic a1);
    @(negedge clk);
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    if (a0 && req0_addr != 4'd0) exp_q.push_back('{a: req0_addr, d: req0_data});
    if (a1 && req1_addr != 4'd0) exp_q.push_back('{a: req1_addr, d: req1_data});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 24'h0;
    reset_n = 1'b0;
    req0_valid = 1'b0; req0_addr = 4'd0; req0_data = 24'h0;
    req1_valid = 1'b0; req1_addr = 4'd0; req1_data = 24'h0;
    read_address1 = 4'd0; read_address2 = 4'd0;

    #3;
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd1);
    chk("rst_ready1", 32'(req1_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_waddr", 32'(write_address), 32'd0);
    chk("rst_wdata", 32'(write_data), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // 1: idle with undriven payloads
    req0_addr = 'x; req0_data = 'x; req1_addr = 'x; req1_data = 'x;
    read_address1 = 4'd3;
    cycle(acc0, acc1);
    cycle(acc0, acc1);
    chk("idle_we", 32'(write_enable), 32'd0);
    chk("idle_waddr", 32'(write_address), 32'd0);
    chk("idle_wdata", 32'(write_data), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_hazard1", 32'(hazard1), 32'd0);
    chk("idle_ready0", 32'(req0_ready), 32'd1);
    chk("idle_ready1", 32'(req1_ready), 32'd1);

    // 2: single ALU write
    req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 24'h00ABCD;
    cycle(acc0, acc1);
    req0_valid = 1'b0;
    chk("t2_accept", 32'(acc0), 32'd1);
    read_address1 = 4'd3; read_address2 = 4'd4;
    @(negedge clk);
    chk("t2_we", 32'(write_enable), 32'd1);
    chk("t2_hazard1", 32'(hazard1), 32'd1);
    chk("t2_hazard2", 32'(hazard2), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    chk("t2_rf3", 32'(rf[3]), 32'h00ABCD);
    chk("t2_hazard1_clr", 32'(hazard1), 32'd0);
    chk("t2_busy_clr", 32'(busy), 32'd0);
    chk("t2_we_clr", 32'(write_enable), 32'd0);
    tick();

    // 3: same register from both requesters on one edge
    req0_valid = 1'b1; req0_addr = 4'd5; req0_data = 24'h111111;
    req1_valid = 1'b1; req1_addr = 4'd5; req1_data = 24'h222222;
    cycle(acc0, acc1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t3_accept", 32'({acc0, acc1}), 32'd3);
    read_address1 = 4'd5;
    @(negedge clk);
    chk("t3_we_a", 32'(write_enable), 32'd1);
    chk("t3_hazard_a", 32'(hazard1), 32'd1);
    chk("t3_ready0_a", 32'(req0_ready), 32'd1);
    chk("t3_ready1_a", 32'(req1_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("t3_we_b", 32'(write_enable), 32'd1);
    chk("t3_hazard_b", 32'(hazard1), 32'd1);
    chk("t3_ready1_b", 32'(req1_ready), 32'd1);
    tick();
    @(negedge clk);
    chk("t3_hazard_c", 32'(hazard1), 32'd0);
    chk("t3_rf5", 32'(rf[5]), 32'h222222);
    chk("t3_busy", 32'(busy), 32'd0);
    tick();

    // 5: load writeback to r0 drains silently
    req1_valid = 1'b1; req1_addr = 4'd0; req1_data = 24'hFFFFFF;
    read_address1 = 4'd0;
    cycle(acc0, acc1);
    req1_valid = 1'b0;
    chk("t5_accept", 32'(acc1), 32'd1);
    @(negedge clk);
    chk("t5_we", 32'(write_enable), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_hazard1", 32'(hazard1), 32'd0);
    tick();
    @(negedge clk);
    chk("t5_busy_clr", 32'(busy), 32'd0);
    chk("t5_rf0", 32'(rf[0]), 32'd0);
    tick();

    // 6: reset with both slots full, before the commit negedge
    req0_valid = 1'b1; req0_addr = 4'd7; req0_data = 24'h777777;
    req1_valid = 1'b1; req1_addr = 4'd8; req1_data = 24'h888888;
    cycle(acc0, acc1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    read_address1 = 4'd7; read_address2 = 4'd8;
    chk("t6_busy_pre", 32'(busy), 32'd1);
    chk("t6_we_pre", 32'(write_enable), 32'd1);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_we_rst", 32'(write_enable), 32'd0);
    chk("t6_busy_rst", 32'(busy), 32'd0);
    chk("t6_hazard1_rst", 32'(hazard1), 32'd0);
    chk("t6_hazard2_rst", 32'(hazard2), 32'd0);
    chk("t6_waddr_rst", 32'(write_address), 32'd0);
    @(negedge clk);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_rf7", 32'(rf[7]), 32'd0);
    chk("t6_rf8", 32'(rf[8]), 32'd0);
    chk("t6_busy_post", 32'(busy), 32'd0);
    tick();

    // 4: both requesters continuously valid for 10 cycles
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 10; c++) begin
      req0_valid = 1'b1; req0_addr = 4'(1 + (i0 % 7)); req0_data = 24'hA00000 | 24'(i0);
      req1_valid = 1'b1; req1_addr = 4'(8 + (i1 % 8)); req1_data = 24'hB00000 | 24'(i1);
      @(negedge clk);
      chk("t4_we", 32'(write_enable), 32'(c > 0));
      if (req0_ready) begin
        exp_q.push_back('{a: req0_addr, d: req0_data});
        i0++;
      end
      if (req1_ready) begin
        exp_q.push_back('{a: req1_addr, d: req1_data});
        i1++;
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t4_count0", 32'(i0), 32'd6);
    chk("t4_count1", 32'(i1), 32'd5);
    @(negedge clk);
    chk("t4_we_drain_a", 32'(write_enable), 32'd1);
    tick();
    @(negedge clk);
    chk("t4_we_drain_b", 32'(write_enable), 32'd1);
    tick();
    @(negedge clk);
    chk("t4_we_done", 32'(write_enable), 32'd0);
    chk("t4_busy_done", 32'(busy), 32'd0);
    tick();
    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
